exec_sequencer: RTL
===================

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 Parameter MAX_WAIT, default 15: maximum memory-wait cycles per handshake before a timeout error.
REQ-002 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 run  in  1  level; 1 = keep sequencing instructions, 0 = halt in IDLE after the current instruction retires.
REQ-006 opcode  in  11  instruction opcode from the IR; valid from DECODE onward; compared against `LDUR, `STUR, `ADD, `SUB, `AND, `ORR, `CBZ, `B.
REQ-007 zero  in  1  iExecute zero flag; sampled in EXEC.
REQ-008 mem_ready  in  1  memory completion for the current mem_req.
REQ-009 mem_req  out  1  memory request; shared by instruction fetch and data access.
REQ-010 mem_we  out  1  write strobe; qualifies mem_req.
REQ-011 ir_write, reg_write, mem_to_reg, alu_src  out  1 each  datapath enables.
REQ-012 alu_op  out  2  `ALUOp_DTYPE / `ALUOp_RTYPE / `ALUOp_CBZ / `ALUOp_B.
REQ-013 pc_write, pc_src  out  1 each  PC load; pc_src=1 selects branch_target, 0 selects cur_pc+4.
REQ-014 done  out  1  one-cycle pulse on instruction retire.
REQ-015 err  out  1  sticky error flag.
REQ-016 instr_count  out  CNT_W  number of instructions retired.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, DECODE, EXEC, MEM, WB, ERROR; outputs are Moore-decoded from the state and the latched opcode class.
REQ-018 IDLE: all strobes 0; run=1 -> FETCH on the next edge.
REQ-019 FETCH: mem_req=1, mem_we=0; ir_write=1 in the cycle mem_ready=1; ready -> DECODE.
REQ-020 DECODE (1 cycle): latch the opcode class; unrecognised opcode -> ERROR; otherwise -> EXEC.
REQ-021 EXEC (1 cycle): alu_op/alu_src per class (D: DTYPE,1; R: RTYPE,0; CBZ: CBZ,0; B: B,0); R -> WB; LDUR/STUR -> MEM; CBZ/B retire here.
REQ-022 MEM: mem_req=1, mem_we=1 for STUR; held until mem_ready; on ready LDUR -> WB, STUR retires.
REQ-023 WB (1 cycle): reg_write=1; mem_to_reg=1 for LDUR only; retires.
REQ-024 Retire cycle: pc_write=1 and done=1 for exactly one cycle; instr_count increments, wrapping at 2^CNT_W; next state FETCH if run=1, else IDLE.
REQ-025 pc_src=1 only on retire of B, or of CBZ with zero=1; otherwise 0.
REQ-026 Zero-wait latency: CBZ/B 3 cycles, R-type 4, STUR 4, LDUR 5; each mem_ready wait cycle adds 1.
REQ-027 A wait counter SHALL clear on entering FETCH or MEM and increment each cycle mem_req=1 with mem_ready=0; reaching MAX_WAIT -> ERROR.
REQ-028 ERROR: all strobes 0, err=1; held until rst; run is ignored.
REQ-029 run falling mid-instruction SHALL NOT abort it; the instruction completes and the FSM then enters IDLE.
REQ-030 mem_req SHALL drop in the cycle after mem_ready; mem_ready while mem_req=0 is ignored.

Reset
REQ-031 With rst=1 at an edge: state=IDLE, wait counter=0, instr_count=0, err=0, and every output 0; this holds in any state, including ERROR and mid-handshake.

Verification
REQ-032 run=1, ADD, mem_ready tied 1 -> done at cycle 4, reg_write=1 only in WB, pc_src=0, instr_count=1.
REQ-033 LDUR with mem_ready delayed 2 cycles in MEM -> mem_req held 3 cycles with mem_we=0, mem_to_reg=1 in WB, done at cycle 7.
REQ-034 CBZ with zero=1, then CBZ with zero=0 -> pc_src 1 then 0 at retire, each in 3 cycles, no reg_write.
REQ-035 STUR, mem_ready never asserted, MAX_WAIT=15 -> ERROR after 15 wait cycles, err=1, mem_req=0; rst clears err and instr_count.
REQ-036 Opcode 11'h000 -> ERROR from DECODE, no pc_write.
REQ-037 run dropped during EXEC of ORR -> WB completes, done=1, then IDLE with no new mem_req; rst asserted during FETCH -> IDLE next cycle.

Source files
------------

// File: rtl/exec_sequencer.sv
// Multi-cycle control sequencer for a LEGv8 subset: fetch, decode, execute,
// memory and write-back phases with a bounded memory handshake and sticky error.
module exec_sequencer #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [10:0]      opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             pc_write,
  output logic             pc_src,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] instr_count,
  output logic [2:0]       dbg_state
);

  localparam logic [1:0] ALUOP_DTYPE = 2'b00;
  localparam logic [1:0] ALUOP_CBZ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_B     = 2'b11;

  localparam int WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERROR
  } state_t;

  typedef enum logic [2:0] {
    C_LDUR, C_STUR, C_RTYPE, C_CBZ, C_B, C_BAD
  } cls_t;

  state_t        state;
  cls_t          cls;
  logic [WW-1:0] wait_cnt;
  logic          retire;
  logic          waiting;

  // CBZ carries an 8-bit opcode and B a 6-bit opcode; low bits are offset.
  function automatic cls_t classify(input logic [10:0] op);
    casez (op)
      11'b111_1100_0010: return C_LDUR;
      11'b111_1100_0000: return C_STUR;
      11'b100_0101_1000,
      11'b110_0101_1000,
      11'b100_0101_0000,
      11'b101_0101_0000: return C_RTYPE;
      11'b101_1010_0???: return C_CBZ;
      11'b000_101?_????: return C_B;
      default:           return C_BAD;
    endcase
  endfunction

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALUOP_DTYPE;
    pc_src     = 1'b0;
    err        = 1'b0;
    retire     = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
      end
      S_EXEC: begin
        case (cls)
          C_LDUR, C_STUR: begin
            alu_op  = ALUOP_DTYPE;
            alu_src = 1'b1;
          end
          C_RTYPE: alu_op = ALUOP_RTYPE;
          C_CBZ: begin
            alu_op = ALUOP_CBZ;
            retire = 1'b1;
            pc_src = zero;
          end
          C_B: begin
            alu_op = ALUOP_B;
            retire = 1'b1;
            pc_src = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls == C_STUR);
        retire  = mem_ready && (cls == C_STUR);
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls == C_LDUR);
        retire     = 1'b1;
      end
      S_ERROR: err = 1'b1;
      default: ;
    endcase
    pc_write = retire;
    done     = retire;
  end

  assign waiting   = mem_req && !mem_ready;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cls         <= C_BAD;
      wait_cnt    <= '0;
      instr_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
          end
        end
        S_FETCH, S_MEM: begin
          if (waiting) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == WAIT_LAST) state <= S_ERROR;
          end else if (state == S_FETCH) begin
            state <= S_DECODE;
          end else if (cls == C_LDUR) begin
            state <= S_WB;
          end
        end
        S_DECODE: begin
          cls   <= classify(opcode);
          state <= (classify(opcode) == C_BAD) ? S_ERROR : S_EXEC;
        end
        S_EXEC: begin
          if (cls == C_RTYPE) begin
            state <= S_WB;
          end else if (cls == C_LDUR || cls == C_STUR) begin
            state    <= S_MEM;
            wait_cnt <= '0;
          end
        end
        default: ;
      endcase
      // Retirement overrides the per-state next-state choice above.
      if (retire) begin
        instr_count <= instr_count + CNT_W'(1);
        state       <= run ? S_FETCH : S_IDLE;
        wait_cnt    <= '0;
      end
    end
  end

endmodule
